// File: rtl/lut_encoder.sv
// Reverse lookup for the PC-target LUT: finds the lowest table entry equal to a
// requested target by scanning one entry per cycle, behind valid/ready handshakes.
module lut_encoder #(
    parameter int AW = 3,
    parameter int TW = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [TW-1:0] wr_data,
    input  logic          req_valid,
    input  logic [TW-1:0] req_target,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [AW-1:0] rsp_addr,
    output logic          rsp_hit,
    input  logic          rsp_ready
);

    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tgt_q, tgt_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;
    logic          rsp_hit_q, rsp_hit_d;
    logic [TW-1:0] table_q [DEPTH];
    logic [TW-1:0] table_d [DEPTH];

    // Boot-time target map shared with the fetch unit's LUT.
    function automatic logic [TW-1:0] reset_entry(input int i);
        case (i)
            1:       reset_entry = TW'(351);
            2:       reset_entry = TW'(418);
            3:       reset_entry = TW'(390);
            7:       reset_entry = TW'(1023);
            default: reset_entry = '0;
        endcase
    endfunction

    // NOTE: the table is a small flop array, so it is reset like any other
    // state; a RAM-backed table could not be restored by reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tgt_q      <= '0;
            rsp_addr_q <= '0;
            rsp_hit_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) table_q[i] <= reset_entry(i);
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tgt_q      <= tgt_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_hit_q  <= rsp_hit_d;
            table_q    <= table_d;
        end
    end

    // The compare reads table_q, so a write landing on the same edge is not seen.
    always_comb begin
        table_d = table_q;
        if (wr_en) table_d[wr_addr] = wr_data;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tgt_d      = tgt_q;
        rsp_addr_d = rsp_addr_q;
        rsp_hit_d  = rsp_hit_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tgt_d   = req_target;
                    idx_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (table_q[idx_q] == tgt_q) begin
                    rsp_addr_d = idx_q;
                    rsp_hit_d  = 1'b1;
                    state_d    = DONE;
                end else if (idx_q == LAST_IDX) begin
                    rsp_addr_d = '0;
                    rsp_hit_d  = 1'b0;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == DONE);
        rsp_addr  = rsp_addr_q;
        rsp_hit   = rsp_hit_q;
    end

endmodule
